// File: rtl/mem_pkg.sv
// Shared types and constants for the RAM arbiter: FSM states, owner encoding
// and default bus widths.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating count of consecutive arbitrations the loader lost to the CPU.
// at_max_o forces the next loader request to win.
module arb_wait_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM sequencer shared between the CPU memory path and the
// program loader: fixed CPU priority, loader anti-starvation and burst lock.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              ARB_clk,
  input  logic              ARB_rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              cpu_gnt,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              cpu_rvalid,
  output logic              ld_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              lock_q, lock_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  logic at_max;
  logic ld_win, cpu_win;
  logic arb_cycle;
  logic wait_inc, wait_clr;

  // Lock and starvation override CPU priority only while the loader is asking.
  assign arb_cycle = (state_q == IDLE);
  assign ld_win    = ld_req && (lock_q || at_max || !cpu_req);
  assign cpu_win   = cpu_req && !ld_win;
  assign wait_inc  = arb_cycle && cpu_win && ld_req;
  assign wait_clr  = arb_cycle && (ld_win || !ld_req);

  arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk_i    (ARB_clk),
    .rst_i    (ARB_rst),
    .inc_i    (wait_inc),
    .clr_i    (wait_clr),
    .at_max_o (at_max)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    lock_d      = lock_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (ld_win && ld_lock) begin
          lock_d = 1'b1;
        end else if (!ld_lock || !ld_req) begin
          lock_d = 1'b0;
        end
        if (ld_win) begin
          owner_d     = OWN_LD;
          we_d        = ld_we;
          ram_addr_d  = ld_addr;
          ram_wdata_d = ld_wdata;
          state_d     = ACCESS;
        end else if (cpu_win) begin
          owner_d     = OWN_CPU;
          we_d        = cpu_we;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        if (owner_q == OWN_LD) begin
          ld_rdata_d = ram_rdata;
        end else begin
          cpu_rdata_d = ram_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ARB_clk) begin
    if (ARB_rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      lock_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      lock_q      <= lock_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Strobes are gated by reset so a reset cycle never issues a write or grant.
  assign cpu_gnt    = !ARB_rst && (state_q == ACCESS) && (owner_q == OWN_CPU);
  assign ld_gnt     = !ARB_rst && (state_q == ACCESS) && (owner_q == OWN_LD);
  assign ram_we     = !ARB_rst && (state_q == ACCESS) && we_q;
  assign cpu_rvalid = !ARB_rst && (state_q == RESP) && (owner_q == OWN_CPU);
  assign ld_rvalid  = !ARB_rst && (state_q == RESP) && (owner_q == OWN_LD);

  // Read data is forwarded in the strobe cycle, then held by the register.
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign ld_rdata  = ld_rvalid  ? ram_rdata : ld_rdata_q;

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule
